// File: rtl/byte_rx_framer_if.sv
// Byte-stream in / word-stream out bundle for the RX framing stage.
// master = upstream byte source and word consumer; slave = framer.
interface byte_rx_framer_if #(
  parameter int unsigned BYTES = 4
);
  logic [7:0]         data_in;
  logic               valid_in;
  logic [8*BYTES-1:0] data_out;
  logic               valid_out;
  logic               locked;
  logic [7:0]         err_count;

  modport master (
    output data_in, valid_in,
    input  data_out, valid_out, locked, err_count
  );

  modport slave (
    input  data_in, valid_in,
    output data_out, valid_out, locked, err_count
  );
endinterface

// File: rtl/byte_rx_framer.sv
// RX framer: locks on the COM symbol, packs following bytes MSB-first into
// BYTES-wide words, drops lock after IDLE_TIMEOUT bubbles, counts truncated words.
module byte_rx_framer #(
  parameter logic [7:0]  COM          = 8'hBC,
  parameter int unsigned BYTES        = 4,
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input logic            CLK,
  input logic            RESET,
  byte_rx_framer_if.slave bus
);
  localparam int unsigned WORD_W = 8 * BYTES;
  localparam int unsigned CNT_W  = $clog2(BYTES + 1);
  localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [WORD_W-1:0]   pack_q, pack_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                valid_q, valid_d;
  logic                locked_q;
  logic [7:0]          err_q, err_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= SEARCH;
      byte_cnt_q <= '0;
      idle_q     <= '0;
      pack_q     <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      idle_q     <= idle_d;
      pack_q     <= pack_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      locked_q   <= (state_d == LOCKED);
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    idle_d     = idle_q;
    pack_d     = pack_q;
    word_d     = word_q;
    valid_d    = 1'b0;
    err_d      = err_q;

    unique case (state_q)
      SEARCH: begin
        idle_d = '0;
        if (bus.valid_in && bus.data_in == COM) begin
          state_d    = LOCKED;
          byte_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (bus.valid_in) begin
          idle_d = '0;
          if (bus.data_in == COM) begin
            // COM mid-word truncates the partial word
            if (byte_cnt_q != '0) begin
              byte_cnt_d = '0;
              if (err_q != 8'hFF) err_d = err_q + 8'd1;
            end
          end else begin
            for (int unsigned i = 0; i < BYTES; i++) begin
              if (byte_cnt_q == CNT_W'(i)) pack_d[WORD_W-8*(i+1) +: 8] = bus.data_in;
            end
            if (byte_cnt_q == CNT_W'(BYTES - 1)) begin
              word_d     = pack_d;
              valid_d    = 1'b1;
              byte_cnt_d = '0;
            end else begin
              byte_cnt_d = byte_cnt_q + CNT_W'(1);
            end
          end
        end else if (idle_q == IDLE_W'(IDLE_TIMEOUT - 1)) begin
          state_d    = SEARCH;
          idle_d     = '0;
          byte_cnt_d = '0;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
    endcase
  end

  assign bus.data_out  = word_q;
  assign bus.valid_out = valid_q;
  assign bus.locked    = locked_q;
  assign bus.err_count = err_q;
endmodule

// File: tb/tb_byte_rx_framer.sv
// Directed bench for byte_rx_framer; expected words queued at stimulus time
// and checked by a negedge monitor when valid_out pulses.
module tb_byte_rx_framer;
  logic CLK = 1'b0;
  logic RESET;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] exp_q[$];

  byte_rx_framer_if #(.BYTES(4)) bus ();

  byte_rx_framer #(.COM(8'hBC), .BYTES(4), .IDLE_TIMEOUT(16)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.data_in  = b;
    bus.valid_in = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    bus.valid_in = 1'b0;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Scoreboard monitor: every valid_out pulse must match the oldest queued word
  always @(negedge CLK) begin
    if (!RESET && bus.valid_out === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_word", 64'(bus.data_out), 64'hDEAD_0000);
      else                   chk("word", 64'(bus.data_out), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    RESET        = 1'b1;
    bus.data_in  = 8'h00;
    bus.valid_in = 1'b0;
    #1;
    chk("rst_data_out", 64'(bus.data_out), 64'h0);
    chk("rst_valid_out", 64'(bus.valid_out), 64'h0);
    chk("rst_locked", 64'(bus.locked), 64'h0);
    chk("rst_err", 64'(bus.err_count), 64'h0);
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;

    // 1: acquire and first word
    send(8'h25);
    chk("t1_no_lock_on_25", 64'(bus.locked), 64'h0);
    send(8'hBC);
    chk("t1_locked", 64'(bus.locked), 64'h1);
    send(8'hF9); send(8'h4F); send(8'hA6);
    exp_q.push_back(32'hF94FA639);
    send(8'h39);
    chk("t1_valid_out", 64'(bus.valid_out), 64'h1);
    chk("t1_data_out", 64'(bus.data_out), 64'hF94FA639);

    // 2: partial word then idle timeout
    send(8'hA8); send(8'hF9); send(8'h4F);
    chk("t2_no_valid", 64'(bus.valid_out), 64'h0);
    idle(15);
    chk("t2_locked_before_timeout", 64'(bus.locked), 64'h1);
    idle(1);
    chk("t2_unlocked", 64'(bus.locked), 64'h0);
    chk("t2_err", 64'(bus.err_count), 64'h0);
    chk("t2_data_hold", 64'(bus.data_out), 64'hF94FA639);

    // 3: COM mid-word truncation
    send(8'hBC);
    chk("t3_locked", 64'(bus.locked), 64'h1);
    send(8'h11); send(8'h22); send(8'hBC);
    chk("t3_err", 64'(bus.err_count), 64'h1);
    send(8'h33); send(8'h44); send(8'h55);
    exp_q.push_back(32'h33445566);
    send(8'h66);
    chk("t3_data_out", 64'(bus.data_out), 64'h33445566);

    // 4: bubbles inside a word
    send(8'h11); send(8'h22);
    idle(3);
    send(8'h33);
    chk("t4_no_early_valid", 64'(bus.valid_out), 64'h0);
    exp_q.push_back(32'h11223344);
    send(8'h44);
    chk("t4_valid_latency", 64'(bus.valid_out), 64'h1);
    chk("t4_data_out", 64'(bus.data_out), 64'h11223344);
    idle(1);
    chk("t4_single_pulse", 64'(bus.valid_out), 64'h0);

    // 5: no COM in SEARCH, then repeated COM
    idle(16);
    chk("t5_unlocked", 64'(bus.locked), 64'h0);
    for (int i = 0; i < 8; i++) send(8'(i * 8'h11));
    chk("t5_still_unlocked", 64'(bus.locked), 64'h0);
    send(8'hBC); send(8'hBC); send(8'hBC);
    chk("t5_locked", 64'(bus.locked), 64'h1);
    chk("t5_err_unchanged", 64'(bus.err_count), 64'h1);

    // 6: asynchronous reset mid-word
    send(8'h11); send(8'h22);
    #2;
    RESET = 1'b1;
    #1;
    chk("t6_rst_data_out", 64'(bus.data_out), 64'h0);
    chk("t6_rst_locked", 64'(bus.locked), 64'h0);
    chk("t6_rst_err", 64'(bus.err_count), 64'h0);
    chk("t6_rst_valid", 64'(bus.valid_out), 64'h0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    send(8'hBC);
    send(8'hAA); send(8'hBB); send(8'hCC);
    exp_q.push_back(32'hAABBCCDD);
    send(8'hDD);
    chk("t6_data_out", 64'(bus.data_out), 64'hAABBCCDD);
    chk("t6_err", 64'(bus.err_count), 64'h0);

    // 7: error counter saturation
    for (int i = 0; i < 256; i++) begin
      send(8'h5A);
      send(8'hBC);
      if (i == 253) chk("t7_err_254", 64'(bus.err_count), 64'hFE);
      if (i == 254) chk("t7_err_255", 64'(bus.err_count), 64'hFF);
    end
    chk("t7_err_saturated", 64'(bus.err_count), 64'hFF);

    idle(4);
    chk("words_outstanding", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
